// File: rtl/parking_ctrl_n_if.sv
// Parking controller signal bundle: raw sensors and buttons toward the
// controller, spot LEDs, gate drives and lot status back from it.
interface parking_ctrl_n_if #(
    parameter int N_SPOTS = 6,
    parameter int CNT_W   = 8
);
    logic [N_SPOTS-1:0] iSENSOR;
    logic               iBTN_IN;
    logic               iBTN_OUT;
    logic [N_SPOTS-1:0] oLED_GREEN;
    logic [N_SPOTS-1:0] oLED_RED;
    logic               oMOTOR_IN;
    logic               oMOTOR_OUT;
    logic               oGATE_IN_GREEN;
    logic               oGATE_IN_RED;
    logic               oGATE_OUT_GREEN;
    logic               oGATE_OUT_RED;
    logic [CNT_W-1:0]   oFREE_CNT;
    logic               oFULL;
    logic               oDENY;

    // Stimulus / environment side.
    modport master (
        output iSENSOR, iBTN_IN, iBTN_OUT,
        input  oLED_GREEN, oLED_RED, oMOTOR_IN, oMOTOR_OUT,
               oGATE_IN_GREEN, oGATE_IN_RED, oGATE_OUT_GREEN, oGATE_OUT_RED,
               oFREE_CNT, oFULL, oDENY
    );

    // Controller side.
    modport slave (
        input  iSENSOR, iBTN_IN, iBTN_OUT,
        output oLED_GREEN, oLED_RED, oMOTOR_IN, oMOTOR_OUT,
               oGATE_IN_GREEN, oGATE_IN_RED, oGATE_OUT_GREEN, oGATE_OUT_RED,
               oFREE_CNT, oFULL, oDENY
    );
endinterface

// File: rtl/parking_ctrl_n.sv
// Parametrised parking-lot controller: debounced spot sensors and request
// buttons, spot LEDs, free-space count / full flag, and two independent
// timed barrier FSMs (entry gate refuses requests while the lot is full).

// One barrier: IDLE -> OPEN (motor on) -> HOLD (open, motor off) -> IDLE.
module parking_gate_fsm #(
    parameter int OPEN_CYC = 10,
    parameter int HOLD_CYC = 20
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic ev,      // one-cycle request event
    input  logic full,    // refuse requests while high
    output logic motor,
    output logic green,
    output logic red,
    output logic deny
);
    localparam int TMR_MAX = (OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        G_IDLE,
        G_OPEN,
        G_HOLD
    } gate_state_t;

    gate_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             motor_d, green_d, red_d, deny_d;

    // Next state, timer and the registered outputs that follow the next state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        timer_d = timer_q;
        deny_d  = 1'b0;
        unique case (state_q)
            G_IDLE: begin
                if (ev) begin
                    if (full) begin
                        deny_d = 1'b1;
                    end else begin
                        state_d = G_OPEN;
                        timer_d = OPEN_LOAD;
                    end
                end
            end
            G_OPEN: begin
                if (timer_q == '0) begin
                    state_d = G_HOLD;
                    timer_d = HOLD_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            G_HOLD: begin
                if (timer_q == '0) begin
                    state_d = G_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = G_IDLE;
                timer_d = '0;
            end
        endcase
        motor_d = (state_d == G_OPEN);
        green_d = (state_d != G_IDLE);
        red_d   = (state_d == G_IDLE);
    end

    // State, timer and output registers; reset drops the motor at once.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= G_IDLE;
            timer_q <= '0;
            motor   <= 1'b0;
            green   <= 1'b0;
            red     <= 1'b1;
            deny    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            timer_q <= timer_d;
            motor   <= motor_d;
            green   <= green_d;
            red     <= red_d;
            deny    <= deny_d;
        end
    end
endmodule

module parking_ctrl_n #(
    parameter int N_SPOTS       = 6,
    parameter int CNT_W         = 8,
    parameter int DEBOUNCE_CYC  = 50000,
    parameter int GATE_OPEN_CYC = 2500000,
    parameter int GATE_HOLD_CYC = 5000000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    parking_ctrl_n_if.slave  bus
);
    // Conditioned inputs: spots in [N_SPOTS-1:0], then entry and exit button.
    localparam int N_IN   = N_SPOTS + 2;
    localparam int BTN_IN = N_SPOTS;
    localparam int BTN_OT = N_SPOTS + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic [N_IN-1:0]            raw;
    logic [N_IN-1:0]            sync1_q, sync2_q;
    logic [N_IN-1:0]            db_q;
    logic [N_IN-1:0][DB_W-1:0]  db_cnt_q;
    logic [N_SPOTS-1:0]         occ;
    logic [CNT_W-1:0]           popcnt;
    logic [CNT_W-1:0]           free_d;
    logic                       btn_in_prev_q, btn_out_prev_q;
    logic                       ev_in, ev_out;
    logic                       deny_in, deny_out;

    assign raw = {bus.iBTN_OUT, bus.iBTN_IN, bus.iSENSOR};
    assign occ = db_q[N_SPOTS-1:0];

    // Two-flop synchroniser on every raw input.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip after DEBOUNCE_CYC.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            // NOTE: the counter array is a bank of flops, not a RAM, so it is
            // cleared by reset like any other state; a RAM would not be.
            db_cnt_q <= '0;
            db_q     <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Spot LEDs follow the debounced occupancy one cycle later.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bus.oLED_RED   <= '0;
            bus.oLED_GREEN <= '1;
        end else begin
            bus.oLED_RED   <= occ;
            bus.oLED_GREEN <= ~occ;
        end
    end

    // Free count is recomputed from the occupancy vector each cycle, so
    // several spots changing at once land in one update with no saturation.
    always_comb begin
        popcnt = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            popcnt = popcnt + CNT_W'(occ[i]);
        end
        free_d = CNT_W'(N_SPOTS) - popcnt;
    end

    // Registered free count and full flag, updated together.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bus.oFREE_CNT <= CNT_W'(N_SPOTS);
            bus.oFULL     <= (N_SPOTS == 0);
        end else begin
            bus.oFREE_CNT <= free_d;
            bus.oFULL     <= (free_d == '0);
        end
    end

    // Previous debounced button levels for rising-edge detection.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            btn_in_prev_q  <= 1'b0;
            btn_out_prev_q <= 1'b0;
        end else begin
            btn_in_prev_q  <= db_q[BTN_IN];
            btn_out_prev_q <= db_q[BTN_OT];
        end
    end

    assign ev_in  = db_q[BTN_IN] & ~btn_in_prev_q;
    assign ev_out = db_q[BTN_OT] & ~btn_out_prev_q;

    parking_gate_fsm #(
        .OPEN_CYC (GATE_OPEN_CYC),
        .HOLD_CYC (GATE_HOLD_CYC)
    ) u_gate_in (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .ev     (ev_in),
        .full   (bus.oFULL),
        .motor  (bus.oMOTOR_IN),
        .green  (bus.oGATE_IN_GREEN),
        .red    (bus.oGATE_IN_RED),
        .deny   (deny_in)
    );

    // The exit gate is never refused, so its full input is tied low and its
    // deny output stays 0.
    parking_gate_fsm #(
        .OPEN_CYC (GATE_OPEN_CYC),
        .HOLD_CYC (GATE_HOLD_CYC)
    ) u_gate_out (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .ev     (ev_out),
        .full   (1'b0),
        .motor  (bus.oMOTOR_OUT),
        .green  (bus.oGATE_OUT_GREEN),
        .red    (bus.oGATE_OUT_RED),
        .deny   (deny_out)
    );

    assign bus.oDENY = deny_in | deny_out;
endmodule

// File: tb/tb_parking_ctrl_n.sv
// Directed bench for parking_ctrl_n with short debounce and gate timings.
module tb_parking_ctrl_n;
    localparam int N  = 6;
    localparam int CW = 8;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    parking_ctrl_n_if #(.N_SPOTS(N), .CNT_W(CW)) bus ();

    parking_ctrl_n #(
        .N_SPOTS       (N),
        .CNT_W         (CW),
        .DEBOUNCE_CYC  (4),
        .GATE_OPEN_CYC (10),
        .GATE_HOLD_CYC (20)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_idle_gates(input string tag);
        check({tag, "_motor_in"},  32'(bus.oMOTOR_IN), 32'd0);
        check({tag, "_motor_out"}, 32'(bus.oMOTOR_OUT), 32'd0);
        check({tag, "_in_red"},    32'(bus.oGATE_IN_RED), 32'd1);
        check({tag, "_out_red"},   32'(bus.oGATE_OUT_RED), 32'd1);
        check({tag, "_in_green"},  32'(bus.oGATE_IN_GREEN), 32'd0);
        check({tag, "_out_green"}, 32'(bus.oGATE_OUT_GREEN), 32'd0);
    endtask

    initial begin
        int deny_cnt, motor_cnt, green_cnt, rises;
        int rise_in, rise_out, fall_in, fall_out, waited;
        logic prev_motor;

        n_assert = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        bus.iSENSOR  = '0;
        bus.iBTN_IN  = 1'b0;
        bus.iBTN_OUT = 1'b0;
        tick(3);

        // 1: reset state after release.
        rst_n = 1'b1;
        tick(20);
        check("s1_free", 32'(bus.oFREE_CNT), 32'd6);
        check("s1_full", 32'(bus.oFULL), 32'd0);
        check("s1_led_green", 32'(bus.oLED_GREEN), 32'h3f);
        check("s1_led_red", 32'(bus.oLED_RED), 32'h00);
        check("s1_deny", 32'(bus.oDENY), 32'd0);
        check_idle_gates("s1");

        // 2: 3-cycle glitch is ignored; a held edge lands on the 7th edge.
        bus.iSENSOR[2] = 1'b1;
        tick(3);
        bus.iSENSOR[2] = 1'b0;
        tick(10);
        check("s2_glitch_red", 32'(bus.oLED_RED), 32'h00);
        check("s2_glitch_free", 32'(bus.oFREE_CNT), 32'd6);
        bus.iSENSOR[2] = 1'b1;
        tick(6);
        check("s2_red_before", 32'(bus.oLED_RED[2]), 32'd0);
        tick(1);
        check("s2_red_after", 32'(bus.oLED_RED[2]), 32'd1);
        check("s2_free_after", 32'(bus.oFREE_CNT), 32'd5);
        check("s2_green", 32'(bus.oLED_GREEN), 32'h3b);

        // 3: fill the lot (two at once, then the rest); entry is refused.
        bus.iSENSOR[0] = 1'b1;
        bus.iSENSOR[1] = 1'b1;
        tick(10);
        check("s3_free_two", 32'(bus.oFREE_CNT), 32'd3);
        bus.iSENSOR = 6'b111111;
        tick(10);
        check("s3_free_zero", 32'(bus.oFREE_CNT), 32'd0);
        check("s3_full", 32'(bus.oFULL), 32'd1);
        check("s3_green_none", 32'(bus.oLED_GREEN), 32'h00);
        deny_cnt  = 0;
        motor_cnt = 0;
        bus.iBTN_IN = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.oDENY) deny_cnt++;
            if (bus.oMOTOR_IN) motor_cnt++;
            if (t == 7) bus.iBTN_IN = 1'b0;
        end
        check("s3_deny_pulses", 32'(deny_cnt), 32'd1);
        check("s3_motor_in", 32'(motor_cnt), 32'd0);

        // 4: one spot free; open, second press during OPEN is ignored.
        bus.iSENSOR[0] = 1'b0;
        tick(10);
        check("s4_free", 32'(bus.oFREE_CNT), 32'd1);
        check("s4_full", 32'(bus.oFULL), 32'd0);
        motor_cnt  = 0;
        green_cnt  = 0;
        rises      = 0;
        deny_cnt   = 0;
        prev_motor = 1'b0;
        bus.iBTN_IN = 1'b1;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            if (bus.oMOTOR_IN) motor_cnt++;
            if (bus.oGATE_IN_GREEN) green_cnt++;
            if (bus.oDENY) deny_cnt++;
            if (bus.oMOTOR_IN && !prev_motor) rises++;
            prev_motor = bus.oMOTOR_IN;
            bus.iBTN_IN = (t < 4) || (t >= 8 && t < 12);
        end
        check("s4_motor_cycles", 32'(motor_cnt), 32'd10);
        check("s4_green_cycles", 32'(green_cnt), 32'd30);
        check("s4_motor_rises", 32'(rises), 32'd1);
        check("s4_no_deny", 32'(deny_cnt), 32'd0);
        check("s4_back_idle", 32'(bus.oGATE_IN_RED), 32'd1);

        // 5: both buttons in the same cycle; both gates run in lockstep.
        rise_in = -1; rise_out = -1; fall_in = -1; fall_out = -1;
        bus.iBTN_IN  = 1'b1;
        bus.iBTN_OUT = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (bus.oMOTOR_IN  && rise_in  < 0) rise_in  = t;
            if (bus.oMOTOR_OUT && rise_out < 0) rise_out = t;
            if (!bus.oMOTOR_IN  && rise_in  >= 0 && fall_in  < 0) fall_in  = t;
            if (!bus.oMOTOR_OUT && rise_out >= 0 && fall_out < 0) fall_out = t;
            if (t == 6) begin
                bus.iBTN_IN  = 1'b0;
                bus.iBTN_OUT = 1'b0;
            end
        end
        check("s5_rise_in", 32'(rise_in), 32'd7);
        check("s5_rise_same", 32'(rise_out), 32'(rise_in));
        check("s5_fall_same", 32'(fall_out), 32'(fall_in));
        check("s5_open_len", 32'(fall_in - rise_in), 32'd10);
        check_idle_gates("s5_end");

        // 6: asynchronous reset while the entry motor is running.
        bus.iBTN_IN = 1'b1;
        waited = 0;
        while (!bus.oMOTOR_IN && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("s6_motor_started", 32'(bus.oMOTOR_IN), 32'd1);
        tick(3);
        #1 rst_n = 1'b0;
        #1;
        check("s6_motor_async_drop", 32'(bus.oMOTOR_IN), 32'd0);
        check("s6_in_red_async", 32'(bus.oGATE_IN_RED), 32'd1);
        bus.iBTN_IN = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("s6_free_reset", 32'(bus.oFREE_CNT), 32'd6);
        check("s6_full_reset", 32'(bus.oFULL), 32'd0);
        check("s6_green_reset", 32'(bus.oLED_GREEN), 32'h3f);
        check_idle_gates("s6");
        tick(20);
        check("s6_free_redebounced", 32'(bus.oFREE_CNT), 32'd1);
        check("s6_red_redebounced", 32'(bus.oLED_RED), 32'h3e);
        check_idle_gates("s6_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/parking_ctrl_n.md
Name: parking_ctrl_n

Overview:
- Parametrised parking-lot controller. Supersedes the fixed six-spot, two-gate arrangement of separate spot and barrier instances.
- Monitors N_SPOTS occupancy sensors with per-spot debounce and drives the spot LEDs. Maintains a registered free-space count and a full flag.
- Runs independent entry and exit gate FSMs with timed motor pulses. An entry request is refused while the lot is full.
- Sits below the top level. oFREE_CNT and oFULL feed the LCD content block.

Parameters:
- N_SPOTS, 6, number of parking spots (1..255).
- CNT_W, 8, width of free-space count; must satisfy 2^CNT_W > N_SPOTS.
- DEBOUNCE_CYC, 50000, consecutive stable cycles required to accept a sensor or button change (>=2).
- GATE_OPEN_CYC, 2500000, cycles the gate motor output is held high per opening.
- GATE_HOLD_CYC, 5000000, cycles the gate stays in HOLD (open, motor off) before returning to IDLE.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- iSENSOR  in  N_SPOTS  raw spot sensors; 1 = car present.
- iBTN_IN  in  1  raw entry-request button, active-high.
- iBTN_OUT  in  1  raw exit-request button, active-high.
- oLED_GREEN  out  N_SPOTS  1 = spot free.
- oLED_RED  out  N_SPOTS  1 = spot occupied.
- oMOTOR_IN  out  1  entry barrier motor drive.
- oMOTOR_OUT  out  1  exit barrier motor drive.
- oGATE_IN_GREEN, oGATE_IN_RED  out  1 each  entry gate lamps.
- oGATE_OUT_GREEN, oGATE_OUT_RED  out  1 each  exit gate lamps.
- oFREE_CNT  out  CNT_W  number of free spots.
- oFULL  out  1  1 when oFREE_CNT == 0.
- oDENY  out  1  one-cycle pulse when an entry request is refused.

Behaviour:
- Reset (iRST_N low, asynchronous):
  - All synchronisers, debounce counters and debounced states clear to 0.
  - oLED_GREEN = all 1s, oLED_RED = 0.
  - oFREE_CNT = N_SPOTS, oFULL = 0 (1 only if N_SPOTS == 0, which is illegal).
  - Both FSMs go to IDLE: motors 0, gate green lamps 0, gate red lamps 1.
  - oDENY = 0.
  - Reset mid-opening drops the motor immediately. No request is remembered across reset.
- Input conditioning (every sensor and both buttons):
  - Each raw input passes through a 2-FF synchroniser, then a debouncer.
  - Debounce counter increments while the synchronised value differs from the debounced state. It clears on any cycle they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 with the values still differing, the debounced state flips on the next edge and the counter clears.
  - Latency from a clean raw edge to the debounced state change: 2 + DEBOUNCE_CYC cycles. Glitches shorter than DEBOUNCE_CYC cycles are ignored.
- Spot outputs:
  - oLED_RED[i] = debounced occupancy of spot i.
  - oLED_GREEN[i] = its inverse.
  - Both are registered, so they update one cycle after the debounced state.
- Counting:
  - oFREE_CNT = N_SPOTS minus the popcount of debounced occupancy, registered one cycle after the debounced states change.
  - Simultaneous changes on several spots are reflected in a single update. No saturation logic is needed because the value is recomputed, not accumulated.
  - oFULL is registered in the same cycle as oFREE_CNT.
- Button event: one-cycle pulse on the rising edge of the debounced button.
- Gate FSM (identical for entry and exit; states IDLE, OPEN, HOLD):
  - IDLE: motor 0, red lamp 1, green lamp 0.
    - On a button event go to OPEN and load the timer with GATE_OPEN_CYC-1.
    - Entry gate only: if oFULL = 1 in the event cycle, stay in IDLE and assert oDENY for that cycle.
  - OPEN: motor 1, green lamp 1, red lamp 0. Timer decrements; at 0, go to HOLD and load GATE_HOLD_CYC-1.
  - HOLD: motor 0, green lamp 1, red lamp 0. At timer 0, go to IDLE.
  - Button events in OPEN or HOLD are ignored (not queued).
  - The exit gate is never refused.
  - Both gates may be active simultaneously and are fully independent.
- FSM outputs are registered and change on the clock edge of the state transition.
- Each FSM has its own timer, sized to ceil(log2(max(GATE_OPEN_CYC, GATE_HOLD_CYC))) bits.

Test Plan (sim overrides: N_SPOTS=6, DEBOUNCE_CYC=4, GATE_OPEN_CYC=10, GATE_HOLD_CYC=20):
1. Release reset, idle 20 cycles -> oFREE_CNT=6, oFULL=0, oLED_GREEN=6'b111111, motors 0, gate red lamps 1.
2. Raise iSENSOR[2] for 3 cycles then drop it -> no output change. Hold iSENSOR[2] high -> oLED_RED[2]=1 and oFREE_CNT=5 within 2+4+2 cycles of the edge.
3. Occupy all 6 spots (two at once), pulse iBTN_IN for 8 cycles -> oFULL=1, oDENY exactly one 1-cycle pulse, oMOTOR_IN stays 0.
4. With 5 spots occupied, press iBTN_IN -> oMOTOR_IN high for exactly 10 cycles, green lamp high for 30 cycles, then IDLE. A second press during OPEN is ignored.
5. Press iBTN_IN and iBTN_OUT in the same cycle while not full -> both motors rise on the same edge and fall together 10 cycles later.
6. Assert iRST_N low mid-OPEN -> oMOTOR_IN drops immediately without waiting for a clock. After release, outputs match scenario 1 until the sensors re-debounce.
